multicycle_ctrl_fsm: RTL and testbench

//  Main control FSM for the multicycle RV32I core; sits directly upstream of the datapath.

---
 rtl/riscv_ctrl_pkg.sv | 80 ++++++++
 rtl/multicycle_ctrl_fsm_alu_decoder.sv | 34 +++
 rtl/multicycle_ctrl_fsm.sv | 210 +++++++++++++++++++++
 tb/tb_multicycle_ctrl_fsm.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_ctrl_pkg.sv
// ============================================================================
// Module   : riscv_ctrl_pkg
// Purpose  : Shared encodings for the multicycle RV32I control FSM: states,
//            opcodes, ALU operations and datapath mux selects.
//            HALT state exists only when CTRL_ILLEGAL_HALT_EN is defined.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package riscv_ctrl_pkg;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_OP_IMM = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [1:0] SRC_A_PC     = 2'b00;
    localparam logic [1:0] SRC_A_OLD_PC = 2'b01;
    localparam logic [1:0] SRC_A_RD1    = 2'b10;

    localparam logic [1:0] SRC_B_RD2    = 2'b00;
    localparam logic [1:0] SRC_B_IMM    = 2'b01;
    localparam logic [1:0] SRC_B_FOUR   = 2'b10;

    localparam logic [1:0] RES_ALU_REG    = 2'b00;
    localparam logic [1:0] RES_MEM        = 2'b01;
    localparam logic [1:0] RES_ALU_RESULT = 2'b10;

    localparam logic [2:0] IMM_I = 3'd0;
    localparam logic [2:0] IMM_S = 3'd1;
    localparam logic [2:0] IMM_B = 3'd2;
    localparam logic [2:0] IMM_U = 3'd3;
    localparam logic [2:0] IMM_J = 3'd4;

    typedef enum logic [3:0] {
        ALU_ADD    = 4'd0,
        ALU_SUB    = 4'd1,
        ALU_AND    = 4'd2,
        ALU_OR     = 4'd3,
        ALU_XOR    = 4'd4,
        ALU_SLL    = 4'd5,
        ALU_SRL    = 4'd6,
        ALU_SRA    = 4'd7,
        ALU_SLT    = 4'd8,
        ALU_SLTU   = 4'd9,
        ALU_PASS_B = 4'd10
    } alu_op_e;

    typedef enum logic [4:0] {
        S_FETCH       = 5'd0,
        S_FETCH_LATCH = 5'd1,
        S_DECODE      = 5'd2,
        S_MEMADR      = 5'd3,
        S_MEMREAD     = 5'd4,
        S_MEM_WAIT    = 5'd5,
        S_MEMWB       = 5'd6,
        S_MEMWRITE    = 5'd7,
        S_EXEC_R      = 5'd8,
        S_EXEC_I      = 5'd9,
        S_ALUWB       = 5'd10,
        S_BRANCH      = 5'd11,
        S_JALR_ADR    = 5'd12,
        S_JAL         = 5'd13,
        S_LUI         = 5'd14,
`ifdef CTRL_ILLEGAL_HALT_EN
        S_AUIPC       = 5'd15,
        S_HALT        = 5'd16
`else
        S_AUIPC       = 5'd15
`endif
    } state_e;

endpackage

`default_nettype wire

// File: rtl/multicycle_ctrl_fsm_alu_decoder.sv
// ============================================================================
// Module   : alu_decoder
// Purpose  : Combinational funct3/funct7_b5 to ALU operation decode.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module alu_decoder
    import riscv_ctrl_pkg::*;
(
    input  logic [2:0] funct3,
    input  logic       funct7_b5,
    input  logic       is_rtype,
    output alu_op_e    alu_op
);

    always_comb begin
        alu_op = ALU_ADD;
        case (funct3)
            // instr[30] is part of the immediate for ADDI, so only R-type may SUB
            3'b000:  alu_op = (is_rtype && funct7_b5) ? ALU_SUB : ALU_ADD;
            3'b001:  alu_op = ALU_SLL;
            3'b010:  alu_op = ALU_SLT;
            3'b011:  alu_op = ALU_SLTU;
            3'b100:  alu_op = ALU_XOR;
            3'b101:  alu_op = funct7_b5 ? ALU_SRA : ALU_SRL;
            3'b110:  alu_op = ALU_OR;
            default: alu_op = ALU_AND;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/multicycle_ctrl_fsm.sv
// ============================================================================
// Module   : multicycle_ctrl_fsm
// Purpose  : Main control FSM of the multicycle RV32I core; one state per clock.
//            CTRL_ILLEGAL_HALT_EN: undecoded opcodes park the FSM in HALT.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module multicycle_ctrl_fsm
    import riscv_ctrl_pkg::*;
#(
    parameter int ALU_CTRL_W = 4,
    parameter int IMM_SRC_W  = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [6:0]            opcode,
    input  logic [2:0]            funct3,
    input  logic                  funct7_b5,
    input  logic                  zero,
    input  logic                  sign,
    input  logic                  carry,
    input  logic                  overflow,
    output logic                  pc_write,
    output logic                  adr_src,
    output logic                  ir_write,
    output logic                  mem_write,
    output logic                  reg_write,
    output logic [1:0]            result_src,
    output logic [1:0]            alu_src_a,
    output logic [1:0]            alu_src_b,
    output logic [ALU_CTRL_W-1:0] alu_control,
    output logic [IMM_SRC_W-1:0]  imm_src,
    output logic                  illegal_instr
);

    state_e     r_state;
    state_e     w_next_state;
    alu_op_e    w_alu_op;
    alu_op_e    w_dec_op;
    logic [2:0] w_imm;
    logic       w_taken;
    logic       w_is_rtype;

    assign w_is_rtype = (r_state == S_EXEC_R);

    alu_decoder u_alu_decoder (
        .funct3    (funct3),
        .funct7_b5 (funct7_b5),
        .is_rtype  (w_is_rtype),
        .alu_op    (w_dec_op)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next_state;
        end
    end

    // carry is the ALU's not-borrow flag, so unsigned less-than is !carry
    always_comb begin
        w_taken = 1'b0;
        case (funct3)
            3'b000:  w_taken = zero;
            3'b001:  w_taken = !zero;
            3'b100:  w_taken = sign ^ overflow;
            3'b101:  w_taken = !(sign ^ overflow);
            3'b110:  w_taken = !carry;
            3'b111:  w_taken = carry;
            default: w_taken = 1'b0;
        endcase
    end

    always_comb begin
        w_next_state = r_state;
        pc_write     = 1'b0;
        adr_src      = 1'b0;
        ir_write     = 1'b0;
        mem_write    = 1'b0;
        reg_write    = 1'b0;
        result_src   = RES_ALU_REG;
        alu_src_a    = SRC_A_PC;
        alu_src_b    = SRC_B_RD2;
        w_alu_op     = ALU_ADD;
        w_imm        = IMM_I;
        case (r_state)
            S_FETCH: begin
                w_next_state = S_FETCH_LATCH;
            end
            S_FETCH_LATCH: begin
                ir_write     = 1'b1;
                pc_write     = 1'b1;
                alu_src_b    = SRC_B_FOUR;
                result_src   = RES_ALU_RESULT;
                w_next_state = S_DECODE;
            end
            S_DECODE: begin
                // Branch/jump target precomputed into alu_reg for later states
                alu_src_a = SRC_A_OLD_PC;
                alu_src_b = SRC_B_IMM;
                w_imm     = (opcode == OP_JAL) ? IMM_J : IMM_B;
                case (opcode)
                    OP_LOAD, OP_STORE: w_next_state = S_MEMADR;
                    OP_OP:             w_next_state = S_EXEC_R;
                    OP_OP_IMM:         w_next_state = S_EXEC_I;
                    OP_BRANCH:         w_next_state = S_BRANCH;
                    OP_JAL:            w_next_state = S_JAL;
                    OP_JALR:           w_next_state = S_JALR_ADR;
                    OP_LUI:            w_next_state = S_LUI;
                    OP_AUIPC:          w_next_state = S_AUIPC;
`ifdef CTRL_ILLEGAL_HALT_EN
                    default:           w_next_state = S_HALT;
`else
                    default:           w_next_state = S_FETCH;
`endif
                endcase
            end
            S_MEMADR: begin
                alu_src_a    = SRC_A_RD1;
                alu_src_b    = SRC_B_IMM;
                w_imm        = (opcode == OP_LOAD) ? IMM_I : IMM_S;
                w_next_state = (opcode == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
            end
            S_MEMREAD: begin
                adr_src      = 1'b1;
                w_next_state = S_MEM_WAIT;
            end
            S_MEM_WAIT: begin
                adr_src      = 1'b1;
                w_next_state = S_MEMWB;
            end
            S_MEMWB: begin
                result_src   = RES_MEM;
                reg_write    = 1'b1;
                w_next_state = S_FETCH;
            end
            S_MEMWRITE: begin
                adr_src      = 1'b1;
                mem_write    = 1'b1;
                w_next_state = S_FETCH;
            end
            S_EXEC_R: begin
                alu_src_a    = SRC_A_RD1;
                w_alu_op     = w_dec_op;
                w_next_state = S_ALUWB;
            end
            S_EXEC_I: begin
                alu_src_a    = SRC_A_RD1;
                alu_src_b    = SRC_B_IMM;
                w_alu_op     = w_dec_op;
                w_next_state = S_ALUWB;
            end
            S_ALUWB: begin
                reg_write    = 1'b1;
                w_next_state = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a    = SRC_A_RD1;
                w_alu_op     = ALU_SUB;
                pc_write     = w_taken;
                w_next_state = S_FETCH;
            end
            S_JALR_ADR: begin
                alu_src_a    = SRC_A_RD1;
                alu_src_b    = SRC_B_IMM;
                w_next_state = S_JAL;
            end
            S_JAL: begin
                alu_src_a    = SRC_A_OLD_PC;
                alu_src_b    = SRC_B_FOUR;
                pc_write     = 1'b1;
                w_next_state = S_ALUWB;
            end
            S_LUI: begin
                alu_src_b    = SRC_B_IMM;
                w_imm        = IMM_U;
                w_alu_op     = ALU_PASS_B;
                w_next_state = S_ALUWB;
            end
            S_AUIPC: begin
                alu_src_a    = SRC_A_OLD_PC;
                alu_src_b    = SRC_B_IMM;
                w_imm        = IMM_U;
                w_next_state = S_ALUWB;
            end
`ifdef CTRL_ILLEGAL_HALT_EN
            S_HALT: begin
                w_next_state = S_HALT;
            end
`endif
            default: begin
                w_next_state = S_FETCH;
            end
        endcase
    end

    assign alu_control = ALU_CTRL_W'(w_alu_op);
    assign imm_src     = IMM_SRC_W'(w_imm);

`ifdef CTRL_ILLEGAL_HALT_EN
    assign illegal_instr = (r_state == S_HALT);
`else
    assign illegal_instr = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_multicycle_ctrl_fsm.sv
// ============================================================================
// Module   : tb_multicycle_ctrl_fsm
// Purpose  : Scoreboard bench for multicycle_ctrl_fsm with directed instructions.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_multicycle_ctrl_fsm;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [6:0] opcode = 7'd0;
    logic [2:0] funct3 = 3'd0;
    logic       funct7_b5 = 1'b0;
    logic       zero = 1'b0, sign = 1'b0, carry = 1'b0, overflow = 1'b0;
    logic       pc_write, adr_src, ir_write, mem_write, reg_write, illegal_instr;
    logic [1:0] result_src, alu_src_a, alu_src_b;
    logic [3:0] alu_control;
    logic [2:0] imm_src;

    multicycle_ctrl_fsm #(.ALU_CTRL_W(4), .IMM_SRC_W(3)) dut (
        .clk           (clk),
        .reset         (reset),
        .opcode        (opcode),
        .funct3        (funct3),
        .funct7_b5     (funct7_b5),
        .zero          (zero),
        .sign          (sign),
        .carry         (carry),
        .overflow      (overflow),
        .pc_write      (pc_write),
        .adr_src       (adr_src),
        .ir_write      (ir_write),
        .mem_write     (mem_write),
        .reg_write     (reg_write),
        .result_src    (result_src),
        .alu_src_a     (alu_src_a),
        .alu_src_b     (alu_src_b),
        .alu_control   (alu_control),
        .imm_src       (imm_src),
        .illegal_instr (illegal_instr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [18:0] v;
        string       name;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    logic [18:0] w_act;
    assign w_act = {pc_write, adr_src, ir_write, mem_write, reg_write, result_src,
                    alu_src_a, alu_src_b, alu_control, imm_src, illegal_instr};

    // {pcw, adr, irw, memw, regw, result_src, src_a, src_b, alu, imm, illegal}
    function automatic logic [18:0] vec(int pcw, int adr, int irw, int memw, int regw,
                                        int res, int a, int b, int alu, int imm, int ill);
        return {1'(pcw), 1'(adr), 1'(irw), 1'(memw), 1'(regw), 2'(res),
                2'(a), 2'(b), 4'(alu), 3'(imm), 1'(ill)};
    endfunction

    function automatic void push(logic [18:0] v, string n);
        exp_t e;
        e.v    = v;
        e.name = n;
        q.push_back(e);
    endfunction

    always @(negedge clk) begin : monitor
        exp_t e;
        if (q.size() > 0) begin
            e = q.pop_front();
            n_checks++;
            if (w_act === e.v) n_pass++;
            else $display("FAIL %s: got %h required %h", e.name, w_act, e.v);
        end
    end

    task automatic run(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_instr(logic [6:0] op, logic [2:0] f3, logic f7);
        opcode    = op;
        funct3    = f3;
        funct7_b5 = f7;
    endtask

    task automatic fetch_dec(bit is_jal, string n);
        push(vec(0,0,0,0,0, 0,0,0, 0,0,0), {n, "_fetch"});
        push(vec(1,0,1,0,0, 2,0,2, 0,0,0), {n, "_fetch_latch"});
        push(vec(0,0,0,0,0, 0,1,1, 0, is_jal ? 4 : 2, 0), {n, "_decode"});
    endtask

    task automatic alu_instr(logic [6:0] op, logic [2:0] f3, logic f7, int alu, string n);
        set_instr(op, f3, f7);
        fetch_dec(0, n);
        if (op == 7'b0110011) push(vec(0,0,0,0,0, 0,2,0, alu,0,0), {n, "_exec_r"});
        else                  push(vec(0,0,0,0,0, 0,2,1, alu,0,0), {n, "_exec_i"});
        push(vec(0,0,0,0,1, 0,0,0, 0,0,0), {n, "_aluwb"});
        run(5);
    endtask

    task automatic branch(logic [2:0] f3, bit z, bit s, bit c, bit o, int taken, string n);
        set_instr(7'b1100011, f3, 1'b0);
        zero = z; sign = s; carry = c; overflow = o;
        fetch_dec(0, n);
        push(vec(taken,0,0,0,0, 0,2,0, 1,0,0), {n, "_branch"});
        run(4);
        zero = 0; sign = 0; carry = 0; overflow = 0;
    endtask

    initial begin
        set_instr(7'b0000011, 3'b010, 1'b0);
        push(vec(0,0,0,0,0, 0,0,0, 0,0,0), "reset_state");
        run(3);
        reset = 1'b1;

        // R/I-type: ALU op from funct3/funct7_b5; instr[30] ignored for ADDI
        alu_instr(7'b0010011, 3'b000, 1'b0, 0, "addi");
        alu_instr(7'b0010011, 3'b000, 1'b1, 0, "addi_neg");
        alu_instr(7'b0010011, 3'b101, 1'b1, 7, "srai");
        alu_instr(7'b0010011, 3'b101, 1'b0, 6, "srli");
        alu_instr(7'b0110011, 3'b000, 1'b1, 1, "sub");
        alu_instr(7'b0110011, 3'b000, 1'b0, 0, "add");
        alu_instr(7'b0110011, 3'b011, 1'b0, 9, "sltu");
        alu_instr(7'b0110011, 3'b110, 1'b0, 3, "or");
        alu_instr(7'b0110011, 3'b001, 1'b0, 5, "sll");
        alu_instr(7'b0110011, 3'b111, 1'b0, 2, "and");

        branch(3'b000, 1, 0, 0, 0, 1, "beq_t");
        branch(3'b000, 0, 0, 0, 0, 0, "beq_nt");
        branch(3'b001, 0, 0, 0, 0, 1, "bne_t");
        branch(3'b110, 0, 0, 0, 0, 1, "bltu_t");
        branch(3'b111, 0, 0, 0, 0, 0, "bgeu_nt");
        branch(3'b100, 0, 1, 0, 0, 1, "blt_t");
        branch(3'b101, 0, 1, 0, 1, 1, "bge_t");
        branch(3'b010, 1, 1, 1, 1, 0, "f3_010");

        // LW x2,0(x1)
        set_instr(7'b0000011, 3'b010, 1'b0);
        fetch_dec(0, "lw");
        push(vec(0,0,0,0,0, 0,2,1, 0,0,0), "lw_memadr");
        push(vec(0,1,0,0,0, 0,0,0, 0,0,0), "lw_memread");
        push(vec(0,1,0,0,0, 0,0,0, 0,0,0), "lw_mem_wait");
        push(vec(0,0,0,0,1, 1,0,0, 0,0,0), "lw_memwb");
        run(7);

        set_instr(7'b0100011, 3'b010, 1'b0);
        fetch_dec(0, "sw");
        push(vec(0,0,0,0,0, 0,2,1, 0,1,0), "sw_memadr");
        push(vec(0,1,0,1,0, 0,0,0, 0,0,0), "sw_memwrite");
        run(5);

        // JALR x1,0(x1)
        set_instr(7'b1100111, 3'b000, 1'b0);
        fetch_dec(0, "jalr");
        push(vec(0,0,0,0,0, 0,2,1, 0,0,0), "jalr_adr");
        push(vec(1,0,0,0,0, 0,1,2, 0,0,0), "jalr_jal");
        push(vec(0,0,0,0,1, 0,0,0, 0,0,0), "jalr_aluwb");
        run(6);

        set_instr(7'b1101111, 3'b000, 1'b0);
        fetch_dec(1, "jal");
        push(vec(1,0,0,0,0, 0,1,2, 0,0,0), "jal_jal");
        push(vec(0,0,0,0,1, 0,0,0, 0,0,0), "jal_aluwb");
        run(5);

        set_instr(7'b0110111, 3'b000, 1'b0);
        fetch_dec(0, "lui");
        push(vec(0,0,0,0,0, 0,0,1, 10,3,0), "lui_lui");
        push(vec(0,0,0,0,1, 0,0,0, 0,0,0), "lui_aluwb");
        run(5);

        set_instr(7'b0010111, 3'b000, 1'b0);
        fetch_dec(0, "auipc");
        push(vec(0,0,0,0,0, 0,1,1, 0,3,0), "auipc_auipc");
        push(vec(0,0,0,0,1, 0,0,0, 0,0,0), "auipc_aluwb");
        run(5);

        // Reset asserted in the middle of MEMWRITE
        set_instr(7'b0100011, 3'b010, 1'b0);
        fetch_dec(0, "swrst");
        push(vec(0,0,0,0,0, 0,2,1, 0,1,0), "swrst_memadr");
        push(vec(0,1,0,1,0, 0,0,0, 0,0,0), "swrst_memwrite");
        run(4);
        @(negedge clk);
        #1;
        reset = 1'b0;
        push(vec(0,0,0,0,0, 0,0,0, 0,0,0), "rst_mid_memwrite");
        run(1);
        run(1);
        reset = 1'b1;

        // First instruction after release must start cleanly at FETCH
        alu_instr(7'b0010011, 3'b000, 1'b0, 0, "post_rst_addi");

        set_instr(7'b1111111, 3'b000, 1'b0);
        fetch_dec(0, "illegal");
`ifdef CTRL_ILLEGAL_HALT_EN
        for (int i = 0; i < 10; i++) push(vec(0,0,0,0,0, 0,0,0, 0,0,1), "halt");
        run(13);
        reset = 1'b0;
        push(vec(0,0,0,0,0, 0,0,0, 0,0,0), "halt_reset");
        run(1);
        reset = 1'b1;
`else
        run(3);
`endif
        alu_instr(7'b0010011, 3'b000, 1'b0, 0, "after_illegal");

        for (int i = 0; i < 20 && q.size() > 0; i++) @(posedge clk);
        if (q.size() > 0) begin
            n_checks++;
            $display("FAIL drain: got %0d pending required 0", q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
